ctl_sync_initiator: RTL and testbench

- Bus-side initiator for the controller register BRAM: drives the CPU bus port (CTL_EN/WE/BRAM_ADDR/DATA) that the FPGA-side controller consumes.
- On request, writes the EtherCAT sync parameters and the per-transducer cycle table, then sets the sync bit in the control register.
- Then polls until the controller clears the sync bit, or until a timeout expires.
- Used by the on-board bus-master logic and by controller-level benches as the bus driver.

---
 rtl/ctl_sync_initiator_if.sv | 12 +
 rtl/ctl_sync_initiator.sv | 237 +++++++++++++++++++++++
 tb/tb_ctl_sync_initiator.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctl_sync_initiator_if.sv
// CPU-side port of the controller register BRAM.
// The initiator drives address/data/enables; the BRAM returns read data.
interface ctl_sync_initiator_if;
  logic        CTL_EN;
  logic        WE;
  logic [9:0]  BRAM_ADDR;
  logic [15:0] BUS_DATA_OUT;
  logic [15:0] BUS_DATA_IN;

  modport master (output CTL_EN, WE, BRAM_ADDR, BUS_DATA_OUT, input BUS_DATA_IN);
  modport slave  (input CTL_EN, WE, BRAM_ADDR, BUS_DATA_OUT, output BUS_DATA_IN);
endinterface

// File: rtl/ctl_sync_initiator.sv
// Bus initiator: loads EtherCAT sync parameters and the cycle table into the
// controller BRAM, requests a sync, then polls until the controller acks it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for START; inputs are snapshotted on acceptance
// WR_TICKS  | write of sync cycle ticks on the bus
// WR_TIME   | write of sync time word idx (0..3)
// WR_CYCLE  | write of cycle entry idx (0..DEPTH-1)
// RD_CTL    | read of the control register
// RD_WAIT   | read latency; captures control register on the last cycle
// WR_CTL    | write of control register with the sync bit merged in
// POLL_REQ  | poll read of the control register
// POLL_WAIT | read latency; captures poll data on the last cycle
// POLL_CHK  | decide: done, timeout, or poll again
// FINISH    | one-cycle DONE pulse, BUSY low
module ctl_sync_initiator #(
  parameter int         WIDTH                    = 13,
  parameter int         DEPTH                    = 249,
  parameter logic [9:0] ADDR_CTL_REG             = 10'h000,
  parameter logic [9:0] ADDR_EC_SYNC_CYCLE_TICKS = 10'h011,
  parameter logic [9:0] ADDR_EC_SYNC_TIME_0      = 10'h012,
  parameter logic [9:0] ADDR_CYCLE_BASE          = 10'h100,
  parameter int         CTL_REG_SYNC_BIT         = 8,
  parameter int         RD_LATENCY               = 2,
  parameter int         POLL_TIMEOUT             = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [63:0]      ECAT_SYNC_TIME,
  input  logic [15:0]      ECAT_SYNC_CYCLE_TICKS,
  input  logic [WIDTH-1:0] CYCLE [0:DEPTH-1],
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT,
  ctl_sync_initiator_if.master bus
);

  localparam int IW = (DEPTH > 4) ? $clog2(DEPTH) : 2;
  localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int PW = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(RD_LATENCY - 1);
  localparam logic [PW-1:0] LAST_POLL = PW'(POLL_TIMEOUT - 1);
  localparam logic [15:0]   SYNC_MASK = 16'(1 << CTL_REG_SYNC_BIT);

  typedef enum logic [3:0] {
    IDLE, WR_TICKS, WR_TIME, WR_CYCLE, RD_CTL, RD_WAIT,
    WR_CTL, POLL_REQ, POLL_WAIT, POLL_CHK, FINISH
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic [PW-1:0]   poll_cnt, poll_nxt;
  logic [15:0]     ctl_q, ctl_nxt;
  logic            timeout_q, timeout_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;
  logic            en_q, en_nxt;
  logic            we_q, we_nxt;
  logic [9:0]      addr_q, addr_nxt;
  logic [15:0]     dout_q, dout_nxt;
  logic            accept;
  logic [1:0]      word_k;

  logic [63:0]      time_q;
  logic [WIDTH-1:0] cycle_q [0:DEPTH-1];

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    wait_nxt    = wait_cnt;
    poll_nxt    = poll_cnt;
    ctl_nxt     = ctl_q;
    timeout_nxt = timeout_q;
    accept      = 1'b0;

    case (state)
      IDLE: begin
        if (START) begin
          accept      = 1'b1;
          state_nxt   = WR_TICKS;
          timeout_nxt = 1'b0;
          poll_nxt    = '0;
          idx_nxt     = '0;
        end
      end
      WR_TICKS: begin
        state_nxt = WR_TIME;
        idx_nxt   = '0;
      end
      WR_TIME: begin
        if (idx[1:0] == 2'd3) begin
          state_nxt = WR_CYCLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      WR_CYCLE: begin
        if (idx == LAST_IDX) state_nxt = RD_CTL;
        else                 idx_nxt   = idx + 1'b1;
      end
      RD_CTL: begin
        state_nxt = RD_WAIT;
        wait_nxt  = WAIT_LOAD;
      end
      RD_WAIT: begin
        if (wait_cnt == '0) begin
          ctl_nxt   = bus.BUS_DATA_IN;
          state_nxt = WR_CTL;
        end else begin
          wait_nxt = wait_cnt - 1'b1;
        end
      end
      WR_CTL: state_nxt = POLL_REQ;
      POLL_REQ: begin
        state_nxt = POLL_WAIT;
        wait_nxt  = WAIT_LOAD;
      end
      POLL_WAIT: begin
        if (wait_cnt == '0) begin
          ctl_nxt   = bus.BUS_DATA_IN;
          state_nxt = POLL_CHK;
        end else begin
          wait_nxt = wait_cnt - 1'b1;
        end
      end
      POLL_CHK: begin
        if ((ctl_q & SYNC_MASK) == '0) begin
          state_nxt = FINISH;
        end else if (poll_cnt == LAST_POLL) begin
          timeout_nxt = 1'b1;
          state_nxt   = FINISH;
        end else begin
          poll_nxt  = poll_cnt + 1'b1;
          state_nxt = POLL_REQ;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Bus outputs are decoded from the next state so they register in
    // step with it: the cycle spent in a state is the cycle of its access.
    en_nxt   = 1'b0;
    we_nxt   = 1'b0;
    addr_nxt = '0;
    dout_nxt = '0;
    done_nxt = (state_nxt == FINISH);
    busy_nxt = (state_nxt != IDLE) && (state_nxt != FINISH);
    word_k   = idx_nxt[1:0];

    case (state_nxt)
      WR_TICKS: begin
        en_nxt   = 1'b1;
        we_nxt   = 1'b1;
        addr_nxt = ADDR_EC_SYNC_CYCLE_TICKS;
        dout_nxt = ECAT_SYNC_CYCLE_TICKS;
      end
      WR_TIME: begin
        en_nxt   = 1'b1;
        we_nxt   = 1'b1;
        addr_nxt = ADDR_EC_SYNC_TIME_0 + {8'b0, word_k};
        dout_nxt = time_q[{word_k, 4'b0000} +: 16];
      end
      WR_CYCLE: begin
        en_nxt   = 1'b1;
        we_nxt   = 1'b1;
        addr_nxt = ADDR_CYCLE_BASE + 10'(idx_nxt);
        dout_nxt = 16'(cycle_q[idx_nxt]);
      end
      RD_CTL, POLL_REQ: begin
        en_nxt   = 1'b1;
        addr_nxt = ADDR_CTL_REG;
      end
      WR_CTL: begin
        en_nxt   = 1'b1;
        we_nxt   = 1'b1;
        addr_nxt = ADDR_CTL_REG;
        dout_nxt = ctl_nxt | SYNC_MASK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      poll_cnt  <= '0;
      ctl_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      wait_cnt  <= wait_nxt;
      poll_cnt  <= poll_nxt;
      ctl_q     <= ctl_nxt;
      timeout_q <= timeout_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      en_q      <= en_nxt;
      we_q      <= we_nxt;
      addr_q    <= addr_nxt;
      dout_q    <= dout_nxt;
    end
  end

  // Ticks go out on the acceptance edge straight from the input, so only the
  // later words need a snapshot.
  always_ff @(posedge CLK) begin
    if (accept && !RST) begin
      time_q <= ECAT_SYNC_TIME;
      for (int i = 0; i < DEPTH; i++) cycle_q[i] <= CYCLE[i];
    end
  end

  assign BUSY             = busy_q;
  assign DONE             = done_q;
  assign TIMEOUT          = timeout_q;
  assign bus.CTL_EN       = en_q;
  assign bus.WE           = we_q;
  assign bus.BRAM_ADDR    = addr_q;
  assign bus.BUS_DATA_OUT = dout_q;

endmodule

// File: tb/tb_ctl_sync_initiator.sv
// Bench for ctl_sync_initiator: BRAM responder plus a trace-level model of
// the expected per-cycle bus activity for each accepted request.
module tb_ctl_sync_initiator;
  localparam int WIDTH = 13;
  localparam int DEPTH = 249;
  localparam int RDL   = 2;
  localparam int PTO   = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic [63:0]      ECAT_SYNC_TIME = '0;
  logic [15:0]      ECAT_SYNC_CYCLE_TICKS = '0;
  logic [WIDTH-1:0] CYCLE [0:DEPTH-1];
  logic             BUSY, DONE, TIMEOUT;

  ctl_sync_initiator_if bus();

  ctl_sync_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(RDL), .POLL_TIMEOUT(PTO)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .ECAT_SYNC_TIME(ECAT_SYNC_TIME), .ECAT_SYNC_CYCLE_TICKS(ECAT_SYNC_CYCLE_TICKS),
    .CYCLE(CYCLE), .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT), .bus(bus)
  );

  initial forever #5 CLK = ~CLK;

  // BRAM responder: RDL=2 read pipeline, junk on BUS_DATA_IN when no read is in flight.
  logic [15:0] ctl_mem, rdp0, rdp1;
  logic [15:0] ctl_init = 16'h0045;
  int          clear_at = 3;
  int          rd_count = 0;
  assign bus.BUS_DATA_IN = rdp1;

  always @(posedge CLK) begin
    rdp1 <= rdp0;
    rdp0 <= 16'($urandom);
    if (bus.CTL_EN && bus.WE && bus.BRAM_ADDR == 10'h011) begin
      ctl_mem  <= ctl_init;
      rd_count <= 0;
    end else if (bus.CTL_EN && bus.WE && bus.BRAM_ADDR == 10'h000) begin
      ctl_mem <= bus.BUS_DATA_OUT;
    end else if (bus.CTL_EN && !bus.WE && bus.BRAM_ADDR == 10'h000) begin
      if (clear_at != 0 && rd_count == clear_at) begin
        rdp0    <= ctl_mem & ~16'h0100;
        ctl_mem <= ctl_mem & ~16'h0100;
      end else begin
        rdp0 <= ctl_mem;
      end
      rd_count <= rd_count + 1;
    end
  end

  typedef struct packed {
    logic        en;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] data;
    logic        busy;
    logic        done;
    logic        to;
  } rec_t;

  rec_t exp_q[$];
  rec_t build_q[$];
  logic exp_to = 1'b0;
  bit   checking = 0;
  int   n_cmp = 0, n_bad = 0, cyc_n = 0;
  int   n_wr = 0, n_rd = 0, n_done = 0;
  logic [15:0] d100 = '0;

  function automatic void push(input logic en, input logic we, input logic [9:0] a,
                               input logic [15:0] d, input logic b, input logic dn, input logic t);
    rec_t r;
    r.en = en; r.we = we; r.addr = a; r.data = d; r.busy = b; r.done = dn; r.to = t;
    build_q.push_back(r);
  endfunction

  // Expected cycle-by-cycle trace starting the cycle after acceptance.
  function automatic void build(input logic [15:0] tk, input logic [63:0] tm,
                                input logic [15:0] c0, input int clr);
    int np;
    logic to;
    build_q.delete();
    push(1, 1, 10'h011, tk, 1, 0, 0);
    for (int k = 0; k < 4; k++) push(1, 1, 10'(18 + k), tm[16*k +: 16], 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) push(1, 1, 10'(256 + i), 16'(CYCLE[i]), 1, 0, 0);
    push(1, 0, 10'h000, 16'h0, 1, 0, 0);
    for (int w = 0; w < RDL; w++) push(0, 0, 10'h0, 16'h0, 1, 0, 0);
    push(1, 1, 10'h000, c0 | 16'h0100, 1, 0, 0);
    if (clr >= 1 && clr <= PTO) begin np = clr; to = 1'b0; end
    else                        begin np = PTO; to = 1'b1; end
    for (int p = 0; p < np; p++) begin
      push(1, 0, 10'h000, 16'h0, 1, 0, 0);
      for (int w = 0; w < RDL + 1; w++) push(0, 0, 10'h0, 16'h0, 1, 0, 0);
    end
    push(0, 0, 10'h0, 16'h0, 0, 1, to);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic check_cycle();
    rec_t e;
    logic fin;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin e = '0; e.to = exp_to; end
    fin = e.done;
    if (e.done) exp_to = e.to;
    n_cmp++;
    if (bus.CTL_EN !== e.en || BUSY !== e.busy || DONE !== e.done || TIMEOUT !== e.to ||
        (e.en && bus.WE !== e.we) || (e.en && bus.BRAM_ADDR !== e.addr) ||
        (e.en && e.we && bus.BUS_DATA_OUT !== e.data)) begin
      n_bad++;
      $display("FAIL cycle %0d: got en=%b we=%b addr=%h data=%h busy=%b done=%b to=%b, want en=%b we=%b addr=%h data=%h busy=%b done=%b to=%b",
               cyc_n, bus.CTL_EN, bus.WE, bus.BRAM_ADDR, bus.BUS_DATA_OUT, BUSY, DONE, TIMEOUT,
               e.en, e.we, e.addr, e.data, e.busy, e.done, e.to);
    end
    if (bus.CTL_EN && bus.WE && bus.BRAM_ADDR == 10'h011) begin
      n_wr = 0; n_rd = 0; n_done = 0;
    end
    if (bus.CTL_EN && bus.WE) n_wr++;
    if (bus.CTL_EN && !bus.WE) n_rd++;
    if (bus.CTL_EN && bus.WE && bus.BRAM_ADDR == 10'h100) d100 = bus.BUS_DATA_OUT;
    if (DONE) n_done++;
    if (RST) begin
      exp_q.delete();
      exp_to = 1'b0;
    end else if (exp_q.size() == 0 && !fin && START) begin
      build(ECAT_SYNC_CYCLE_TICKS, ECAT_SYNC_TIME, ctl_init, clear_at);
      exp_q = build_q;
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    if (checking) check_cycle();
    cyc_n++;
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_inputs();
    ECAT_SYNC_CYCLE_TICKS = 16'($urandom);
    ECAT_SYNC_TIME        = {$urandom, $urandom};
    for (int i = 0; i < DEPTH; i++) CYCLE[i] = WIDTH'($urandom);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    cyc();
    START = 1'b0;
  endtask

  // mode 0: quiet inputs; 1: scramble inputs; 2: scramble plus stray START pulses
  task automatic wait_idle(input int mode);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      if (mode >= 1) rand_inputs();
      if (mode == 2) START = ($urandom_range(0, 7) == 0);
      cyc();
      n++;
    end
    START = 1'b0;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: got %0d cycles without completion, want <3000", n);
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) CYCLE[i] = 13'd4096;
    repeat (2) @(posedge CLK);
    #1;
    checking = 1;
    cyc();
    chk("rst_en", 32'(bus.CTL_EN), 32'd0);
    chk("rst_we", 32'(bus.WE), 32'd0);
    chk("rst_addr", 32'(bus.BRAM_ADDR), 32'd0);
    chk("rst_data", 32'(bus.BUS_DATA_OUT), 32'd0);
    chk("rst_busy_done_to", {29'd0, BUSY, DONE, TIMEOUT}, 32'd0);
    RST = 1'b0;
    repeat (3) cyc();

    // Directed: fixed data, controller acks on 3rd poll
    ECAT_SYNC_CYCLE_TICKS = 16'h0032;
    ECAT_SYNC_TIME = 64'h0123_4567_89AB_CDEF;
    ctl_init = 16'h0045;
    clear_at = 3;
    build(ECAT_SYNC_CYCLE_TICKS, ECAT_SYNC_TIME, ctl_init, clear_at);
    chk("model_len", 32'(build_q.size()), 32'd271);
    chk("model_ticks", {build_q[0].addr, build_q[0].data}, {10'h011, 16'h0032});
    chk("model_time0", {build_q[1].addr, build_q[1].data}, {10'h012, 16'hCDEF});
    chk("model_time3", {build_q[4].addr, build_q[4].data}, {10'h015, 16'h0123});
    chk("model_cyc0", {build_q[5].addr, build_q[5].data}, {10'h100, 16'h1000});
    chk("model_cyclast", {build_q[253].addr, build_q[253].data}, {10'h1F8, 16'h1000});
    chk("model_ctlwr", {build_q[257].we, build_q[257].addr, build_q[257].data}, {1'b1, 10'h000, 16'h0145});
    chk("model_done", {build_q[270].done, build_q[270].busy, build_q[270].to}, 32'b100);
    pulse_start();
    chk("busy_after_start", 32'(BUSY), 32'd1);
    wait_idle(0);
    chk("A_writes", n_wr, 32'd255);
    chk("A_reads", n_rd, 32'd4);
    chk("A_done", n_done, 32'd1);
    chk("A_timeout", 32'(TIMEOUT), 32'd0);
    repeat (3) cyc();

    // Same request, second START during write #10 and inputs scrambled afterwards
    ECAT_SYNC_CYCLE_TICKS = 16'h0032;
    ECAT_SYNC_TIME = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < DEPTH; i++) CYCLE[i] = 13'd4096;
    pulse_start();
    repeat (9) cyc();
    rand_inputs();
    pulse_start();
    wait_idle(1);
    chk("A2_writes", n_wr, 32'd255);
    chk("A2_reads", n_rd, 32'd4);
    chk("A2_done", n_done, 32'd1);
    repeat (2) cyc();

    // Sync bit never cleared: timeout after PTO polls
    rand_inputs();
    ctl_init = 16'($urandom);
    clear_at = 0;
    pulse_start();
    wait_idle(0);
    chk("B_reads", n_rd, 32'(1 + PTO));
    chk("B_done", n_done, 32'd1);
    chk("B_timeout", 32'(TIMEOUT), 32'd1);
    repeat (10) cyc();
    chk("B_timeout_sticky", 32'(TIMEOUT), 32'd1);

    // Next START clears TIMEOUT
    rand_inputs();
    clear_at = 1;
    pulse_start();
    chk("C_timeout_cleared", 32'(TIMEOUT), 32'd0);
    wait_idle(0);
    chk("C_reads", n_rd, 32'd2);

    // Full-width cycle entry
    rand_inputs();
    CYCLE[0] = 13'h1FFF;
    clear_at = 2;
    pulse_start();
    wait_idle(0);
    chk("D_cyc0_data", 32'(d100), 32'h1FFF);

    // Reset during WR_CYCLE, then full replay
    rand_inputs();
    pulse_start();
    repeat (60) cyc();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("E_en_after_rst", 32'(bus.CTL_EN), 32'd0);
    chk("E_busy_after_rst", 32'(BUSY), 32'd0);
    repeat (20) cyc();
    chk("E_no_done", n_done, 32'd0);
    clear_at = 3;
    pulse_start();
    wait_idle(0);
    chk("E_replay_writes", n_wr, 32'd255);
    chk("E_replay_done", n_done, 32'd1);

    // Randomized requests with stray START pulses
    for (int r = 0; r < 6; r++) begin
      rand_inputs();
      ctl_init = 16'($urandom);
      clear_at = $urandom_range(0, 5);
      repeat ($urandom_range(0, 3)) cyc();
      pulse_start();
      wait_idle(2);
      chk("R_done", n_done, 32'd1);
    end
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
